// File: rtl/iob_regfile_np.sv
// iob_regfile_np: multi-read-port register file.
// Features: one byte-strobed write port, N_RD independent read ports,
// per-entry valid bits, and a sequential clear sweep that zeroes the array
// one entry per enabled cycle instead of resetting every flop at once.
module iob_regfile_np #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int N_RD   = 2,
  parameter int RD_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     cke_i,
  input  logic                     clr_i,
  output logic                     busy_o,
  input  logic                     wen_i,
  input  logic [DATA_W/8-1:0]      wstrb_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [N_RD*ADDR_W-1:0]   raddr_i,
  output logic [N_RD*DATA_W-1:0]   rdata_o,
  output logic [N_RD-1:0]          rvalid_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    valid;

  logic                busy;
  logic                wr_acc;
  logic                wr_set;
  logic                clr_step;

  logic [N_RD*DATA_W-1:0] rd_comb;
  logic [N_RD-1:0]        rv_comb;
  logic [ADDR_W-1:0]      ra;
  logic                   hit;

  assign busy     = (state == CLEAR);
  assign busy_o   = busy;
  // A write is dropped while the sweep owns the array or during reset.
  assign wr_acc   = rst_n_i & cke_i & wen_i & ~busy;
  assign wr_set   = wr_acc & (|wstrb_i);
  // The sweep only advances on enabled cycles outside reset, so a reset
  // mid-sweep leaves the entry under the counter untouched.
  assign clr_step = rst_n_i & cke_i & busy;

  // Next-state logic for the clear sweep; cke_i low holds everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (cke_i && clr_i) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        if (cke_i) begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Sweep state register and address counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Valid bits: cleared by reset or by the sweep, set by a non-empty write.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid <= '0;
    end else if (clr_step) begin
      valid[cnt] <= 1'b0;
    end else if (wr_set) begin
      valid[waddr_i] <= 1'b1;
    end
  end

  // Data array has no reset; the sweep zeroes it, writes merge per byte.
  always_ff @(posedge clk_i) begin
    if (clr_step) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      for (int j = 0; j < NB; j++) begin
        if (wstrb_i[j]) begin
          mem[waddr_i][j*8 +: 8] <= wdata_i[j*8 +: 8];
        end
      end
    end
  end

  // Per-port read mux with optional forwarding of the accepted write.
  always_comb begin
    rd_comb = '0;
    rv_comb = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int k = 0; k < N_RD; k++) begin
      ra  = raddr_i[k*ADDR_W +: ADDR_W];
      hit = (BYPASS != 0) && wr_acc && (waddr_i == ra);
      rd_comb[k*DATA_W +: DATA_W] = mem[ra];
      for (int j = 0; j < NB; j++) begin
        if (hit && wstrb_i[j]) begin
          rd_comb[k*DATA_W + j*8 +: 8] = wdata_i[j*8 +: 8];
        end
      end
      rv_comb[k] = valid[ra] | (hit & (|wstrb_i));
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [N_RD*DATA_W-1:0] rdata_q;
      logic [N_RD-1:0]        rvalid_q;

      // Registered read: one cycle of latency, frozen while cke_i is low.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          rdata_q  <= '0;
          rvalid_q <= '0;
        end else if (cke_i) begin
          rdata_q  <= rd_comb;
          rvalid_q <= rv_comb;
        end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
    end else begin : g_rd_comb
      assign rdata_o  = rd_comb;
      assign rvalid_o = rv_comb;
    end
  endgenerate

endmodule

// File: tb/tb_iob_regfile_np.sv
// tb_iob_regfile_np: directed self-checking bench for iob_regfile_np.
// A second instance without forwarding shares all inputs so the
// bypass/no-bypass behaviour can be compared on the same traffic.
module tb_iob_regfile_np;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cke_i;
  logic        clr_i;
  logic        wen_i;
  logic [3:0]  wstrb_i;
  logic [2:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [5:0]  raddr_i;

  logic        busy_o, busy_nb;
  logic [63:0] rdata_o, rdata_nb;
  logic [1:0]  rvalid_o, rvalid_nb;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        wen;
    logic [3:0]  wstrb;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [31:0] d0;
    logic        v0;
    logic [31:0] d1;
    logic        v1;
    logic [31:0] nd0;
    logic        nv0;
  } vec_t;

  vec_t vecs [9];

  iob_regfile_np #(.ADDR_W(3), .DATA_W(32), .N_RD(2), .RD_REG(1), .BYPASS(1)) u_dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .cke_i    (cke_i),
    .clr_i    (clr_i),
    .busy_o   (busy_o),
    .wen_i    (wen_i),
    .wstrb_i  (wstrb_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
    .raddr_i  (raddr_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o)
  );

  iob_regfile_np #(.ADDR_W(3), .DATA_W(32), .N_RD(2), .RD_REG(1), .BYPASS(0)) u_dut_nb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .cke_i    (cke_i),
    .clr_i    (clr_i),
    .busy_o   (busy_nb),
    .wen_i    (wen_i),
    .wstrb_i  (wstrb_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
    .raddr_i  (raddr_i),
    .rdata_o  (rdata_nb),
    .rvalid_o (rvalid_nb)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wen_i   = v.wen;
    wstrb_i = v.wstrb;
    waddr_i = v.waddr;
    wdata_i = v.wdata;
    raddr_i = {v.ra1, v.ra0};
  endtask

  task automatic writeEntry(input logic [2:0] a, input logic [31:0] d);
    wen_i   = 1'b1;
    wstrb_i = 4'hF;
    waddr_i = a;
    wdata_i = d;
    tick();
    wen_i   = 1'b0;
  endtask

  // Pulse clr_i and count busy cycles, bounded so a stuck sweep cannot hang.
  task automatic sweepCount(output int n);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy_o) break;
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{1'b1, 4'hF, 3'd3, 32'hDEADBEEF, 3'd3, 3'd3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0};
    vecs[1] = '{1'b1, 4'h1, 3'd3, 32'h000000AA, 3'd3, 3'd0, 32'hDEADBEAA, 1'b1, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b0, 4'h0, 3'd0, 32'h00000000, 3'd3, 3'd3, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA, 1'b1};
    vecs[3] = '{1'b1, 4'h0, 3'd2, 32'hFFFFFFFF, 3'd2, 3'd3, 32'h00000000, 1'b0, 32'hDEADBEAA, 1'b1, 32'h00000000, 1'b0};
    vecs[4] = '{1'b1, 4'hF, 3'd5, 32'h12345678, 3'd5, 3'd5, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 32'h00000000, 1'b0};
    vecs[5] = '{1'b1, 4'h6, 3'd5, 32'hAABBCCDD, 3'd5, 3'd2, 32'h12BBCC78, 1'b1, 32'h00000000, 1'b0, 32'h12345678, 1'b1};
    vecs[6] = '{1'b0, 4'h0, 3'd0, 32'h00000000, 3'd5, 3'd3, 32'h12BBCC78, 1'b1, 32'hDEADBEAA, 1'b1, 32'h12BBCC78, 1'b1};
    vecs[7] = '{1'b1, 4'h8, 3'd0, 32'h11223344, 3'd1, 3'd0, 32'h00000000, 1'b0, 32'h11000000, 1'b1, 32'h00000000, 1'b0};
    vecs[8] = '{1'b0, 4'h0, 3'd0, 32'h00000000, 3'd0, 3'd7, 32'h11000000, 1'b1, 32'h00000000, 1'b0, 32'h11000000, 1'b1};

    rst_n_i = 1'b0;
    cke_i   = 1'b1;
    clr_i   = 1'b0;
    wen_i   = 1'b0;
    wstrb_i = 4'h0;
    waddr_i = 3'd0;
    wdata_i = 32'h0;
    raddr_i = 6'd0;
    repeat (2) tick();

    checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset_rdata0", rdata_o[31:0], 32'h0);
    checkOutput("reset_rdata1", rdata_o[63:32], 32'h0);
    checkOutput("reset_rvalid", {30'b0, rvalid_o}, 32'd0);
    rst_n_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      raddr_i = {3'(7 - i), 3'(i)};
      tick();
      checkOutput($sformatf("post_reset_rvalid_%0d", i), {30'b0, rvalid_o}, 32'd0);
    end

    sweepCount(n);
    checkOutput("init_sweep_busy_cycles", n, 32'd8);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_rdata0", i), rdata_o[31:0], vecs[i].d0);
      checkOutput($sformatf("vec%0d_rvalid0", i), {31'b0, rvalid_o[0]}, {31'b0, vecs[i].v0});
      checkOutput($sformatf("vec%0d_rdata1", i), rdata_o[63:32], vecs[i].d1);
      checkOutput($sformatf("vec%0d_rvalid1", i), {31'b0, rvalid_o[1]}, {31'b0, vecs[i].v1});
      checkOutput($sformatf("vec%0d_nb_rdata0", i), rdata_nb[31:0], vecs[i].nd0);
      checkOutput($sformatf("vec%0d_nb_rvalid0", i), {31'b0, rvalid_nb[0]}, {31'b0, vecs[i].nv0});
    end
    wen_i = 1'b0;

    // Fill, sweep, and try to write entry 7 during the sweep.
    for (int i = 0; i < 8; i++) writeEntry(3'(i), 32'hA0A00000 | i);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checkOutput("sweep_busy_start", {31'b0, busy_o}, 32'd1);
    n = busy_o ? 1 : 0;
    wen_i   = 1'b1;
    wstrb_i = 4'hF;
    waddr_i = 3'd7;
    wdata_i = 32'hFFFFFFFF;
    raddr_i = {3'd7, 3'd7};
    tick();
    wen_i = 1'b0;
    checkOutput("sweep_drop_bypass", rdata_o[31:0], 32'hA0A00007);
    checkOutput("sweep_drop_nb", rdata_nb[31:0], 32'hA0A00007);
    if (busy_o) n++;
    for (int c = 0; c < 20; c++) begin
      if (!busy_o) break;
      tick();
      if (busy_o) n++;
    end
    checkOutput("sweep_busy_cycles", n, 32'd8);

    for (int i = 0; i < 8; i++) begin
      raddr_i = {3'(7 - i), 3'(i)};
      tick();
      checkOutput($sformatf("swept_rdata0_%0d", i), rdata_o[31:0], 32'h0);
      checkOutput($sformatf("swept_rdata1_%0d", i), rdata_o[63:32], 32'h0);
      checkOutput($sformatf("swept_rvalid_%0d", i), {30'b0, rvalid_o}, 32'd0);
    end

    // Clock enable low freezes everything, including write and clear.
    writeEntry(3'd1, 32'h5555AAAA);
    raddr_i = {3'd0, 3'd1};
    tick();
    checkOutput("cke_pre_read", rdata_o[31:0], 32'h5555AAAA);
    cke_i   = 1'b0;
    wen_i   = 1'b1;
    wstrb_i = 4'hF;
    waddr_i = 3'd1;
    wdata_i = 32'h0;
    clr_i   = 1'b1;
    raddr_i = {3'd0, 3'd2};
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("cke_busy_%0d", c), {31'b0, busy_o}, 32'd0);
      checkOutput($sformatf("cke_hold_rdata_%0d", c), rdata_o[31:0], 32'h5555AAAA);
    end
    cke_i   = 1'b1;
    wen_i   = 1'b0;
    clr_i   = 1'b0;
    raddr_i = {3'd0, 3'd1};
    tick();
    checkOutput("cke_no_write", rdata_o[31:0], 32'h5555AAAA);
    checkOutput("cke_no_clear", {31'b0, busy_o}, 32'd0);

    // Reset aborts a sweep after entries 0..3 have been cleared.
    for (int i = 0; i < 8; i++) writeEntry(3'(i), 32'hC0C00000 | i);
    raddr_i = {3'd6, 3'd6};
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    repeat (4) tick();
    checkOutput("abort_busy_before", {31'b0, busy_o}, 32'd1);
    rst_n_i = 1'b0;
    tick();
    checkOutput("abort_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("abort_rdata0", rdata_o[31:0], 32'h0);
    checkOutput("abort_rvalid", {30'b0, rvalid_o}, 32'd0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raddr_i = {3'(i), 3'(i)};
      tick();
      checkOutput($sformatf("abort_rdata_%0d", i), rdata_o[31:0], (i < 4) ? 32'h0 : (32'hC0C00000 | i));
      checkOutput($sformatf("abort_rvalid_%0d", i), {30'b0, rvalid_o}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/iob_regfile_np.md
Name: iob_regfile_np

Overview:
Parametrised multi-read-port register file: one write port with byte strobes, N_RD independent read ports, selectable combinational or registered read, and optional write-to-read bypass. Per-entry valid bits and a sequential clear engine sweep the array to zero without a wide reset fan-out. Used as a shared register store for multi-issue or multi-channel datapaths in IOb cores.

Parameters:
ADDR_W, 3, address width; depth DEPTH = 2**ADDR_W (ADDR_W >= 1)
DATA_W, 32, entry width; must be a multiple of 8
N_RD, 2, number of read ports (>= 1)
RD_REG, 1, 0 = combinational read, 1 = registered read (1-cycle latency)
BYPASS, 1, 1 = same-cycle write forwarded to matching reads, 0 = no forwarding

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  reset, synchronous, active-low
cke_i  in  1  clock enable; low freezes all state
clr_i  in  1  start sequential clear sweep (pulse)
busy_o  out  1  clear sweep in progress
wen_i  in  1  write enable
wstrb_i  in  DATA_W/8  byte strobes
waddr_i  in  ADDR_W  write address
wdata_i  in  DATA_W  write data
raddr_i  in  N_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rdata_o  out  N_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rvalid_o  out  N_RD  per-port entry-valid flag, same timing as rdata_o

Behaviour:
- Reset (rst_n_i=0 at rising edge, regardless of cke_i): all valid bits 0, FSM -> IDLE, sweep counter 0, busy_o=0, registered rdata_o=0 and rvalid_o=0. Data array not reset (contents undefined until written or cleared).
- cke_i=0: no state changes (array, valid bits, FSM, counter, read registers); writes and clr_i ignored. Combinational outputs still follow inputs.
- Write: accepted when rst_n_i=1, cke_i=1, wen_i=1, busy_o=0. Byte j of entry waddr_i updated iff wstrb_i[j]=1; valid bit set iff wstrb_i != 0. wstrb_i=0 is a no-op.
- Read data for port k: entry raddr_k contents plus valid bit. If BYPASS=1 and an accepted write targets raddr_k in the same cycle, strobed bytes come from wdata_i, others from the array, and rvalid=1.
- RD_REG=0: rdata_o/rvalid_o combinational from raddr_i. Without bypass a write is visible the next cycle.
- RD_REG=1: read value sampled at edge t appears on rdata_o from t until next enabled edge (1-cycle latency). Without bypass, same-cycle write returns old data; visible for reads issued next cycle.
- All read ports independent; any ports may share an address.
- FSM: IDLE -> CLEAR on clr_i=1 (with cke_i=1); clr_i ignored while in CLEAR.
- CLEAR: one entry per enabled cycle, address = counter 0..DEPTH-1; entry set to 0, valid bit cleared. After entry DEPTH-1 -> IDLE, counter -> 0. busy_o=1 for exactly DEPTH enabled cycles, starting the cycle after clr_i is sampled.
- During CLEAR, writes dropped (no array or valid change); reads allowed and return current contents (already-swept entries read 0/invalid). Bypass is inactive for dropped writes.
- Reset mid-sweep aborts: IDLE, busy_o=0, valid bits 0; swept entries are 0, others keep their data.
- Counter wraps only by returning to IDLE; there is no free-running wrap.

Test Plan:
- Reset then read all addresses on both ports -> rvalid_o=0 everywhere; RD_REG=1: rdata_o=0 immediately after reset.
- Write 0xDEADBEEF @3 with wstrb=0xF, then 0x000000AA @3 with wstrb=0x1; read port0 @3 -> 0xDEADBEAA, rvalid=1 (RD_REG=1: value appears 1 cycle after raddr).
- BYPASS=1, RD_REG=1: write 0x12345678 @5 while port0 and port1 both read @5 in the same cycle -> next cycle both ports show 0x12345678, rvalid=1; with BYPASS=0 -> old value, rvalid=0.
- Fill all 8 entries, pulse clr_i -> busy_o high exactly 8 cycles; write @7 during sweep is dropped; after sweep all reads return 0, rvalid=0.
- Hold cke_i=0 for 3 cycles with wen_i=1 and clr_i=1 -> no write occurs, busy_o stays 0, registered rdata_o unchanged.
- Assert rst_n_i=0 at sweep count 4 -> busy_o=0 next cycle; entries 0-3 read 0, entries 4-7 keep data with rvalid=0.
